// File: rtl/regfile_write_scheduler_if.sv
// Register-file write scheduler bus.
// Bundles write-back requests, issue-stage reservations and the registered
// strobe / port-select / conflict / busy results.
//   enable      : global qualifier
//   wr_en       : per-port write request          [NUM_PORTS]
//   wr_addr     : per-port destination            [NUM_PORTS*ADDR_W]
//   rsv_en      : reserve a destination register
//   rsv_addr    : register to reserve             [ADDR_W]
//   wr_strobe   : registered write strobes        [NUM_REGS]
//   wr_port_sel : registered winning port per reg [NUM_REGS*PSEL_W]
//   wr_conflict : registered same-register conflict pulse
//   busy        : reservation scoreboard          [NUM_REGS]
// Modports: master drives requests, slave is the scheduler.
interface regfile_write_scheduler_if #(
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned NUM_PORTS = 2
);
    localparam int unsigned PSEL_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic                          enable;
    logic [NUM_PORTS-1:0]          wr_en;
    logic [NUM_PORTS*ADDR_W-1:0]   wr_addr;
    logic                          rsv_en;
    logic [ADDR_W-1:0]             rsv_addr;
    logic [NUM_REGS-1:0]           wr_strobe;
    logic [NUM_REGS*PSEL_W-1:0]    wr_port_sel;
    logic                          wr_conflict;
    logic [NUM_REGS-1:0]           busy;

    modport master (
        output enable, wr_en, wr_addr, rsv_en, rsv_addr,
        input  wr_strobe, wr_port_sel, wr_conflict, busy
    );

    modport slave (
        input  enable, wr_en, wr_addr, rsv_en, rsv_addr,
        output wr_strobe, wr_port_sel, wr_conflict, busy
    );
endinterface

// File: rtl/regfile_write_scheduler.sv
// Register-file write scheduler.
// Decodes NUM_PORTS write requests into a registered write-strobe vector
// with a per-register winning-port select, flags same-cycle conflicts
// (highest port index wins), and keeps a busy scoreboard of reserved
// registers for hazard/forwarding logic.
// Ports:
//   clk   : clock, all state on rising edge
//   reset : synchronous, active-high
//   bus   : regfile_write_scheduler_if.slave (requests in, results out)
// Optional feature macro: ZERO_REG_MASK_EN -- when defined, register
// ZERO_REG is never strobed, never reserved and never busy.
module regfile_write_scheduler #(
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned ZERO_REG  = 31
) (
    input  logic                        clk,
    input  logic                        reset,
    regfile_write_scheduler_if.slave    bus
);
    localparam int unsigned PSEL_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [NUM_PORTS-1:0]        w_valid;
    logic [NUM_REGS-1:0]         w_strobe;
    logic [NUM_REGS*PSEL_W-1:0]  w_sel;
    logic                        w_conflict;
    logic [NUM_REGS-1:0]         w_rsv;
    logic                        w_rsv_ok;

    logic [NUM_REGS-1:0]         r_strobe;
    logic [NUM_REGS*PSEL_W-1:0]  r_sel;
    logic                        r_conflict;
    logic [NUM_REGS-1:0]         r_busy;

    // Port qualification: enabled, requested, in range, not the zero reg.
    always_comb begin
        w_valid = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            w_valid[p] = bus.enable && bus.wr_en[p] &&
                         (32'(bus.wr_addr[p*ADDR_W +: ADDR_W]) < NUM_REGS);
`ifdef ZERO_REG_MASK_EN
            if (32'(bus.wr_addr[p*ADDR_W +: ADDR_W]) == ZERO_REG)
                w_valid[p] = 1'b0;
`endif
        end
    end

    // Ports are scanned in ascending order so the last match, i.e. the
    // highest port index, ends up owning the select field.
    always_comb begin
        w_strobe   = '0;
        w_sel      = '0;
        w_conflict = 1'b0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (w_valid[p] && (32'(bus.wr_addr[p*ADDR_W +: ADDR_W]) == r)) begin
                    if (w_strobe[r])
                        w_conflict = 1'b1;
                    w_strobe[r]                = 1'b1;
                    w_sel[r*PSEL_W +: PSEL_W]  = PSEL_W'(p);
                end
            end
        end
    end

    always_comb begin
        w_rsv_ok = bus.enable && bus.rsv_en && (32'(bus.rsv_addr) < NUM_REGS);
`ifdef ZERO_REG_MASK_EN
        if (32'(bus.rsv_addr) == ZERO_REG)
            w_rsv_ok = 1'b0;
`endif
        w_rsv = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            w_rsv[r] = w_rsv_ok && (32'(bus.rsv_addr) == r);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_strobe   <= '0;
            r_sel      <= '0;
            r_conflict <= 1'b0;
            r_busy     <= '0;
        end else begin
            r_strobe   <= w_strobe;
            r_sel      <= w_sel;
            r_conflict <= w_conflict;
            // Clear uses the strobe being registered this edge; a same-edge
            // reservation is OR'd in last so the new producer is tracked.
            if (bus.enable)
                r_busy <= (r_busy & ~w_strobe) | w_rsv;
        end
    end

    assign bus.wr_strobe   = r_strobe;
    assign bus.wr_port_sel = r_sel;
    assign bus.wr_conflict = r_conflict;
    assign bus.busy        = r_busy;
endmodule

// File: tb/tb_regfile_write_scheduler.sv
module tb_regfile_write_scheduler;
    localparam int unsigned ADDR_W    = 5;
    localparam int unsigned NUM_REGS  = 24;
    localparam int unsigned NUM_PORTS = 2;
    localparam int unsigned ZERO_REG  = 23;

    typedef struct packed {
        logic [NUM_REGS-1:0] strobe;
        logic [NUM_REGS-1:0] sel;      // PSEL_W == 1: bit r is port index
        logic                conflict;
        logic [NUM_REGS-1:0] busy;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t q[$];

    regfile_write_scheduler_if #(
        .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .NUM_PORTS(NUM_PORTS)
    ) bus ();

    regfile_write_scheduler #(
        .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS),
        .NUM_PORTS(NUM_PORTS), .ZERO_REG(ZERO_REG)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [NUM_REGS-1:0] bit_of(input int unsigned i);
        logic [NUM_REGS-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic check(input string tag);
        exp_t e;
        e = q.pop_front();
        n_cmp++;
        assert (bus.wr_strobe === e.strobe) else begin
            n_fail++;
            $error("FAIL %s strobe: got %h want %h", tag, bus.wr_strobe, e.strobe);
        end
        n_cmp++;
        assert (bus.wr_port_sel === e.sel) else begin
            n_fail++;
            $error("FAIL %s port_sel: got %h want %h", tag, bus.wr_port_sel, e.sel);
        end
        n_cmp++;
        assert (bus.wr_conflict === e.conflict) else begin
            n_fail++;
            $error("FAIL %s conflict: got %b want %b", tag, bus.wr_conflict, e.conflict);
        end
        n_cmp++;
        assert (bus.busy === e.busy) else begin
            n_fail++;
            $error("FAIL %s busy: got %h want %h", tag, bus.busy, e.busy);
        end
    endtask

    // Drive one cycle of stimulus, queue the expected registered result,
    // then sample just after the active edge.
    task automatic step(input string tag, input logic rst, input logic en,
                        input logic [1:0] we, input int unsigned a0,
                        input int unsigned a1, input logic rv,
                        input int unsigned ra, input exp_t e);
        reset        = rst;
        bus.enable   = en;
        bus.wr_en    = we;
        bus.wr_addr  = {ADDR_W'(a1), ADDR_W'(a0)};
        bus.rsv_en   = rv;
        bus.rsv_addr = ADDR_W'(ra);
        q.push_back(e);
        @(posedge clk);
        #1;
        check(tag);
        @(negedge clk);
    endtask

    localparam logic [NUM_REGS-1:0] Z = '0;
    logic [NUM_REGS-1:0] b12;

    initial begin
        reset = 1'b1;
        bus.enable = 1'b0; bus.wr_en = '0; bus.wr_addr = '0;
        bus.rsv_en = 1'b0; bus.rsv_addr = '0;
        b12 = bit_of(12);
        @(negedge clk);

        step("rst0", 1, 1, 2'b11, 5, 6, 1, 7, '{Z, Z, 1'b0, Z});
        step("rst1", 1, 1, 2'b11, 5, 6, 1, 7, '{Z, Z, 1'b0, Z});
        step("post_rst", 0, 1, 2'b00, 0, 0, 0, 0, '{Z, Z, 1'b0, Z});
        step("single", 0, 1, 2'b01, 5, 0, 0, 0, '{bit_of(5), Z, 1'b0, Z});
        step("single_end", 0, 1, 2'b00, 0, 0, 0, 0, '{Z, Z, 1'b0, Z});
        step("dual", 0, 1, 2'b11, 3, 17, 0, 0,
             '{bit_of(3) | bit_of(17), bit_of(17), 1'b0, Z});
        step("conflict", 0, 1, 2'b11, 9, 9, 0, 0, '{bit_of(9), bit_of(9), 1'b1, Z});
        step("conflict_end", 0, 1, 2'b00, 0, 0, 0, 0, '{Z, Z, 1'b0, Z});
        step("rsv12", 0, 1, 2'b00, 0, 0, 1, 12, '{Z, Z, 1'b0, b12});
        step("hold1", 0, 1, 2'b00, 0, 0, 0, 0, '{Z, Z, 1'b0, b12});
        step("hold2", 0, 1, 2'b00, 0, 0, 0, 0, '{Z, Z, 1'b0, b12});
        step("wr12_clear", 0, 1, 2'b01, 12, 0, 0, 0, '{b12, Z, 1'b0, Z});
        step("idle", 0, 1, 2'b00, 0, 0, 0, 0, '{Z, Z, 1'b0, Z});
        step("set_wins", 0, 1, 2'b10, 0, 12, 1, 12, '{b12, b12, 1'b0, b12});
        step("disabled", 0, 0, 2'b11, 1, 2, 1, 4, '{Z, Z, 1'b0, b12});
        step("rsv_again", 0, 1, 2'b00, 0, 0, 1, 12, '{Z, Z, 1'b0, b12});
        step("out_range", 0, 1, 2'b01, 30, 0, 1, 30, '{Z, Z, 1'b0, b12});
`ifdef ZERO_REG_MASK_EN
        step("zero_wr_rsv", 0, 1, 2'b01, 23, 0, 1, 23, '{Z, Z, 1'b0, b12});
        step("zero_both", 0, 1, 2'b11, 23, 23, 0, 0, '{Z, Z, 1'b0, b12});
`else
        step("zero_wr_rsv", 0, 1, 2'b01, 23, 0, 1, 23,
             '{bit_of(23), Z, 1'b0, b12 | bit_of(23)});
        step("zero_both", 0, 1, 2'b11, 23, 23, 0, 0,
             '{bit_of(23), bit_of(23), 1'b1, b12});
`endif
        step("drop_port0", 0, 1, 2'b11, 25, 0, 0, 0, '{bit_of(0), bit_of(0), 1'b0, b12});
        step("mid_reset", 1, 1, 2'b11, 4, 8, 1, 6, '{Z, Z, 1'b0, Z});
        step("after_reset", 0, 1, 2'b00, 0, 0, 0, 0, '{Z, Z, 1'b0, Z});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
